// File: rtl/wx_horner_poly_if.sv
// Stream bundle for the Horner evaluator: sample input stream and result output stream.
interface wx_horner_poly_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 48
);
  logic [DATA_W-1:0] axis_s_tdata;
  logic              axis_s_tvalid;
  logic              axis_s_tready;
  logic [OUT_W-1:0]  axis_m_tdata;
  logic              axis_m_tuser;
  logic              axis_m_tvalid;
  logic              axis_m_tready;

  modport slave (
    input  axis_s_tdata, axis_s_tvalid, axis_m_tready,
    output axis_s_tready, axis_m_tdata, axis_m_tuser, axis_m_tvalid
  );

  modport master (
    output axis_s_tdata, axis_s_tvalid, axis_m_tready,
    input  axis_s_tready, axis_m_tdata, axis_m_tuser, axis_m_tvalid
  );
endinterface

// File: rtl/wx_horner_poly.sv
// Sequential polynomial evaluator, one Horner multiply-accumulate per cycle.
// state | meaning
// IDLE  | ready for a sample; accept latches x and coefficients
// CALC  | one Horner step per cycle, step counts down to 0
// DONE  | result held on the output until the consumer takes it
module wx_horner_poly #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int DEGREE = 3,
  parameter int OUT_W  = 48
) (
  input  logic                         in_clock,
  input  logic                         in_reset,
  input  logic [(DEGREE+1)*COEF_W-1:0] coef,
  wx_horner_poly_if.slave              axis
);
  localparam int STEP_W = $clog2(DEGREE + 1);
  localparam int FULL_W = OUT_W + DATA_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [OUT_W-1:0]  acc;
  logic              ovf;
  logic [STEP_W-1:0] step;
  logic [DATA_W-1:0] x_q;
  logic [COEF_W-1:0] c_q [DEGREE+1];

  logic [STEP_W-1:0] step_m1;
  logic [FULL_W-1:0] full;
  logic              accept;

  assign step_m1 = step - STEP_W'(1);
  // Wide enough that nothing is lost before the overflow test.
  assign full    = FULL_W'(acc) * FULL_W'(x_q) + FULL_W'(c_q[step_m1]);

  assign axis.axis_s_tready = (state == IDLE) && !in_reset;
  assign accept             = axis.axis_s_tvalid && axis.axis_s_tready;

  assign axis.axis_m_tvalid = (state == DONE);
  assign axis.axis_m_tdata  = acc;
  assign axis.axis_m_tuser  = ovf;

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      step  <= '0;
      x_q   <= '0;
      for (int i = 0; i <= DEGREE; i++) c_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_q <= axis.axis_s_tdata;
            for (int i = 0; i <= DEGREE; i++) c_q[i] <= coef[i*COEF_W +: COEF_W];
            acc   <= OUT_W'(coef[DEGREE*COEF_W +: COEF_W]);
            ovf   <= 1'b0;
            step  <= STEP_W'(DEGREE);
            state <= CALC;
          end
        end
        CALC: begin
          acc  <= full[OUT_W-1:0];
          ovf  <= ovf | (|full[FULL_W-1:OUT_W]);
          step <= step_m1;
          if (step == STEP_W'(1)) state <= DONE;
        end
        DONE: begin
          if (axis.axis_m_tready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wx_horner_poly.sv
// Self-checking bench for wx_horner_poly against an exact power-sum model.
module tb_wx_horner_poly;
  localparam logic [63:0] C_DEF = {16'd1, 16'd2, 16'd1, 16'd1};

  logic        clk;
  logic        rst;
  logic [63:0] coef;
  int          total;
  int          passed;
  logic [47:0] last_data;
  logic        last_user;
  logic        seen;

  wx_horner_poly_if #(.DATA_W(16), .OUT_W(48)) bus ();

  wx_horner_poly #(.DATA_W(16), .COEF_W(16), .DEGREE(3), .OUT_W(48)) dut (
    .in_clock (clk),
    .in_reset (rst),
    .coef     (coef),
    .axis     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact W(x) as a sum of c[i]*x^i; bit 48 of the return is the overflow flag.
  function automatic logic [48:0] model(input logic [63:0] cf, input logic [15:0] x);
    logic [127:0] sum;
    logic [127:0] p;
    sum = '0;
    p   = 128'd1;
    for (int i = 0; i <= 3; i++) begin
      sum = sum + 128'(cf[i*16 +: 16]) * p;
      p   = p * 128'(x);
    end
    return {(sum >= (128'd1 << 48)), sum[47:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send(input logic [15:0] x, input string tag);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.axis_s_tready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_s_tready"}, 64'(bus.axis_s_tready), 64'd1);
    bus.axis_s_tdata  = x;
    bus.axis_s_tvalid = 1'b1;
    @(posedge clk); #1;
    bus.axis_s_tvalid = 1'b0;
  endtask

  task automatic do_sample(input logic [15:0] x, input int hold, input bit offer,
                           input bit zap, input string tag);
    logic [48:0] exp;
    int          lat;
    exp = model(coef, x);
    bus.axis_m_tready = (hold == 0);
    send(x, tag);
    if (zap) coef = '0;
    lat = 0;
    while (!bus.axis_m_tvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    check({tag, "_lat"}, 64'(lat), 64'd3);
    check({tag, "_data"}, 64'(bus.axis_m_tdata), 64'(exp[47:0]));
    check({tag, "_user"}, 64'(bus.axis_m_tuser), 64'(exp[48]));
    last_data = bus.axis_m_tdata;
    last_user = bus.axis_m_tuser;
    if (offer) begin
      bus.axis_s_tdata  = 16'h1234;
      bus.axis_s_tvalid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(bus.axis_m_tvalid), 64'd1);
      check({tag, "_hold_data"}, 64'(bus.axis_m_tdata), 64'(exp[47:0]));
      check({tag, "_hold_user"}, 64'(bus.axis_m_tuser), 64'(exp[48]));
      check({tag, "_hold_s_tready"}, 64'(bus.axis_s_tready), 64'd0);
    end
    bus.axis_s_tvalid = 1'b0;
    bus.axis_m_tready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_post_valid"}, 64'(bus.axis_m_tvalid), 64'd0);
    check({tag, "_post_s_tready"}, 64'(bus.axis_s_tready), 64'd1);
    if (offer) begin
      seen = 1'b0;
      repeat (5) begin @(posedge clk); #1; if (bus.axis_m_tvalid) seen = 1'b1; end
      check({tag, "_not_consumed"}, 64'(seen), 64'd0);
    end
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b0;
    coef = C_DEF;
    bus.axis_s_tdata  = '0;
    bus.axis_s_tvalid = 1'b0;
    bus.axis_m_tready = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("rst_m_tvalid", 64'(bus.axis_m_tvalid), 64'd0);
    check("rst_m_tdata", 64'(bus.axis_m_tdata), 64'd0);
    check("rst_m_tuser", 64'(bus.axis_m_tuser), 64'd0);
    check("rst_s_tready", 64'(bus.axis_s_tready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rel_s_tready", 64'(bus.axis_s_tready), 64'd1);

    do_sample(16'd3, 0, 1'b0, 1'b0, "x3");
    check("x3_value", 64'(last_data), 64'd49);
    do_sample(16'd0, 0, 1'b0, 1'b0, "x0");
    check("x0_value", 64'(last_data), 64'd1);
    do_sample(16'hFFFF, 0, 1'b0, 1'b0, "xmax");
    check("xmax_value", 64'(last_data), 64'hFFFF_0000_0001);
    check("xmax_ovf", 64'(last_user), 64'd0);

    coef = {16'hFFFF, 48'd0};
    do_sample(16'hFFFF, 0, 1'b0, 1'b0, "ovf");
    check("ovf_flag", 64'(last_user), 64'd1);

    coef = C_DEF;
    do_sample(16'd3, 5, 1'b1, 1'b0, "bp");
    check("bp_value", 64'(last_data), 64'd49);

    do_sample(16'd3, 0, 1'b0, 1'b1, "zap");
    check("zap_value", 64'(last_data), 64'd49);

    coef = C_DEF;
    bus.axis_m_tready = 1'b1;
    send(16'd3, "mid_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_m_tvalid", 64'(bus.axis_m_tvalid), 64'd0);
    check("midrst_m_tdata", 64'(bus.axis_m_tdata), 64'd0);
    check("midrst_m_tuser", 64'(bus.axis_m_tuser), 64'd0);
    check("midrst_s_tready", 64'(bus.axis_s_tready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (bus.axis_m_tvalid) seen = 1'b1; end
    check("midrst_no_pulse", 64'(seen), 64'd0);
    do_sample(16'd2, 0, 1'b0, 1'b0, "x2");
    check("x2_value", 64'(last_data), 64'd19);

    for (int k = 0; k < 16; k++) begin
      coef = {$urandom, $urandom};
      do_sample((k % 4 == 0) ? 16'hFFFF : 16'($urandom), int'($urandom_range(0, 3)),
                1'b0, 1'b0, "rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
